lfsr_range_generator: RTL and testbench
=======================================

Name: lfsr_range_generator

Overview:
Parametrised Fibonacci-LFSR random source that returns numbers uniformly distributed in 0..limit on request. A req/valid/ready handshake serves the game controller. Rejection sampling produces each value, with a bounded retry count and a deterministic fallback. Supports reseeding from an external entropy source and guards against the all-zero lock-up state.

Parameters:
WIDTH, 8, LFSR and output width in bits (>=3).
TAPS, 8'hB8, feedback tap mask; bit i set means state[i] is XORed into feedback (default taps 7,5,4,3).
SEED, 8'hA5, reset seed and zero-state replacement value (must be nonzero).
MAX_TRIES, 16, maximum rejection attempts per request (>=1).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  free-run advance of the LFSR while IDLE
seed_load  in  1  load seed_in into the LFSR this cycle
seed_in  in  WIDTH  external seed (entropy)
req  in  1  request a new value
limit  in  WIDTH  inclusive upper bound, sampled when req is accepted
ready  in  1  consumer accepts value
req_ready  out  1  high in IDLE only
valid  out  1  value available
value  out  WIDTH  random result
fallback  out  1  value came from the fallback path
state_o  out  WIDTH  raw LFSR state (debug and free entropy)

Behaviour:
- Reset (async): state=SEED, FSM=IDLE, valid=0, value=0, fallback=0, tries=0, lim=0, mask=0.
- LFSR step: fb = ^(state & TAPS); next = {state[WIDTH-2:0], fb}. If state==0, next=SEED.
- State update priority per edge:
  1. seed_load: state = (seed_in==0) ? SEED : seed_in.
  2. Otherwise, step when (FSM==IDLE && en) or FSM==SEARCH.
  3. Otherwise, hold.
- FSM IDLE: req_ready=1. On req: latch lim=limit, set mask = smallest 2^k-1 >= limit (limit=0 gives mask=0), tries=0, go to SEARCH.
- FSM SEARCH: cand = state & mask, using the pre-step register value. The LFSR steps on the same edge.
  - If cand <= lim: value=cand, fallback=0, valid=1, go to DONE.
  - Else if tries == MAX_TRIES-1: value = cand - (lim+1), which is always <= lim because mask < 2*(lim+1); fallback=1, valid=1, go to DONE.
  - Else: tries++ and stay in SEARCH.
- FSM DONE: valid, value and fallback are held stable until ready=1. On ready: valid=0, go to IDLE. req is ignored outside IDLE.
- Latency: req accepted at edge N; first candidate evaluated in cycle N+1; valid rises at edge N+1+r, where r = rejections (0..MAX_TRIES-1). Minimum 2 cycles from req to valid.
- Boundaries:
  - limit = all-ones: mask = all-ones, always accepted on first try.
  - limit = 0: value is always 0.
  - seed_load during SEARCH: the load wins for that edge, the candidate from the old state is still evaluated, and the search continues from the loaded state.
  - rst mid-operation: immediate return to reset values; no partial result is emitted.
- All arithmetic is unsigned WIDTH bits. The tries counter is $clog2(MAX_TRIES)+1 bits.

Decomposition:
- Package lfsr_pkg: default TAPS/SEED constants per common WIDTH (8, 16, 32), an FSM state enum (IDLE, SEARCH, DONE), and a function mask_for(limit) returning the smallest 2^k-1 >= limit.
- Sub-module lfsr_core (WIDTH, TAPS, SEED): holds the state register, step/load logic and zero-guard. It exposes state and a step/load interface. The FSM and range logic stay in the top module.

Test Plan:
- Reset, en=0, req with limit=0xFF. The first candidate is 0xA5. Required: valid exactly 2 cycles after req, value=0xA5, fallback=0. After ready, req_ready=1 again.
- Reset, en=0, req with limit=0x20 (mask 0x3F). Candidate 0x25 is rejected; next candidate 0x4A&0x3F=0x0A is accepted. Required: value=0x0A, valid 3 cycles after req.
- MAX_TRIES=1, reset, req with limit=0x20. Required: value=0x04 (0x25-0x21), fallback=1.
- Reset, en=1 for 4 cycles. Required: state_o sequence A5, 4A, 95, 2A, 54. Then seed_load with seed_in=0: state_o=0xA5. Then seed_in=0x3C: state_o=0x3C.
- Hold ready=0 for 5 cycles after valid. Required: value/valid stable; req pulses ignored (req_ready=0). Then assert rst during SEARCH: valid=0, state_o=0xA5 immediately.
- Random regression, 10k requests with random limits. Required: every value <= limit. With limit=9 the histogram is uniform within ±5% when fallback=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR range generator.
// mask_for covers limits up to 32 bits wide.
package lfsr_pkg;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [7:0]  SEED_8  = 8'hA5;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [15:0] SEED_16 = 16'hACE1;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;
  localparam logic [31:0] SEED_32 = 32'h1234_5678;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } fsm_state_t;

  // Smear the highest set bit downwards: smallest 2^k-1 that covers limit.
  function automatic logic [31:0] mask_for(input logic [31:0] limit);
    logic [31:0] m;
    m = limit;
    for (int i = 0; i < 5; i++) begin
      m = m | (m >> (1 << i));
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_range_generator_if.sv
// Request/result handshake between the game controller (master) and the
// range generator (slave).
interface lfsr_range_generator_if #(
  parameter int WIDTH = 8
);
  logic             req;
  logic [WIDTH-1:0] limit;
  logic             ready;
  logic             req_ready;
  logic             valid;
  logic [WIDTH-1:0] value;
  logic             fallback;

  modport master (
    output req, limit, ready,
    input  req_ready, valid, value, fallback
  );

  modport slave (
    input  req, limit, ready,
    output req_ready, valid, value, fallback
  );
endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with seed load and all-zero lock-up guard.
// A load always takes priority over a step on the same edge.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] tapped;
  logic [WIDTH-1:0] step_value;
  logic             fb;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_taps
    assign tapped[gi] = state_reg[gi] & TAPS[gi];
  end

  assign fb         = ^tapped;
  assign step_value = (state_reg == '0) ? SEED : {state_reg[WIDTH-2:0], fb};

  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = (load_value == '0) ? SEED : load_value;
    end else if (step) begin
      state_next = step_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SEED;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/lfsr_range_generator.sv
// Uniform random values in 0..limit via rejection sampling on an LFSR,
// with a bounded retry count and a wrap-around fallback.
module lfsr_range_generator
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_8),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(SEED_8),
  parameter int               MAX_TRIES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    seed_load,
  input  logic [WIDTH-1:0]        seed_in,
  lfsr_range_generator_if.slave   bus,
  output logic [WIDTH-1:0]        state_o
);

  localparam int               TRY_W    = $clog2(MAX_TRIES) + 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  fsm_state_t       fsm_reg, fsm_next;
  logic [WIDTH-1:0] lim_reg, lim_next;
  logic [WIDTH-1:0] mask_reg, mask_next;
  logic [TRY_W-1:0] tries_reg, tries_next;
  logic [WIDTH-1:0] value_reg, value_next;
  logic             fallback_reg, fallback_next;
  logic             valid_reg, valid_next;

  logic             step;
  logic [WIDTH-1:0] lfsr_state;
  logic [WIDTH-1:0] cand;

  assign step = ((fsm_reg == IDLE) && en) || (fsm_reg == SEARCH);

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .load       (seed_load),
    .load_value (seed_in),
    .state      (lfsr_state)
  );

  // Candidate comes from the pre-step state; the core advances on the same edge.
  assign cand = lfsr_state & mask_reg;

  always_comb begin
    fsm_next      = fsm_reg;
    lim_next      = lim_reg;
    mask_next     = mask_reg;
    tries_next    = tries_reg;
    value_next    = value_reg;
    fallback_next = fallback_reg;
    valid_next    = valid_reg;
    case (fsm_reg)
      IDLE: begin
        if (bus.req) begin
          lim_next   = bus.limit;
          mask_next  = WIDTH'(mask_for(32'(bus.limit)));
          tries_next = '0;
          fsm_next   = SEARCH;
        end
      end
      SEARCH: begin
        if (cand <= lim_reg) begin
          value_next    = cand;
          fallback_next = 1'b0;
          valid_next    = 1'b1;
          fsm_next      = DONE;
        end else if (tries_reg == LAST_TRY) begin
          // mask < 2*(lim+1), so the wrapped value always lands in range.
          value_next    = cand - (lim_reg + WIDTH'(1));
          fallback_next = 1'b1;
          valid_next    = 1'b1;
          fsm_next      = DONE;
        end else begin
          tries_next = tries_reg + TRY_W'(1);
        end
      end
      DONE: begin
        if (bus.ready) begin
          valid_next = 1'b0;
          fsm_next   = IDLE;
        end
      end
      default: begin
        fsm_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg      <= IDLE;
      lim_reg      <= '0;
      mask_reg     <= '0;
      tries_reg    <= '0;
      value_reg    <= '0;
      fallback_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      fsm_reg      <= fsm_next;
      lim_reg      <= lim_next;
      mask_reg     <= mask_next;
      tries_reg    <= tries_next;
      value_reg    <= value_next;
      fallback_reg <= fallback_next;
      valid_reg    <= valid_next;
    end
  end

  assign bus.req_ready = (fsm_reg == IDLE);
  assign bus.valid     = valid_reg;
  assign bus.value     = value_reg;
  assign bus.fallback  = fallback_reg;
  assign state_o       = lfsr_state;

endmodule

// File: tb/tb_lfsr_range_generator.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop and compare.
// dut0 uses MAX_TRIES=16, dut1 uses MAX_TRIES=1 to force the fallback path.
module tb_lfsr_range_generator;

  typedef struct {
    logic [7:0] lim;
    logic [7:0] val;
    logic       fb;
    bit         bound_only;
    int         lat;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       seed_load = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic [7:0] state0, state1;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  exp_t       q0[$];
  exp_t       q1[$];

  lfsr_range_generator_if #(.WIDTH(8)) bus0 ();
  lfsr_range_generator_if #(.WIDTH(8)) bus1 ();

  lfsr_range_generator #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hA5), .MAX_TRIES(16)) dut0 (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .bus(bus0), .state_o(state0)
  );

  lfsr_range_generator #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hA5), .MAX_TRIES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .bus(bus1), .state_o(state1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [7:0] lim, input logic [7:0] val, input logic fb,
                              input bit bound_only, input int lat);
    exp_t e;
    e.lim = lim; e.val = val; e.fb = fb; e.bound_only = bound_only; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [7:0] v, input logic f);
    $display("[TB] %s result value=%02h fallback=%0d limit=%02h", tag, v, f, e.lim);
    if (e.bound_only) begin
      tests++;
      if (v > e.lim) begin
        fails++;
        $display("FAIL %s_bound: value %02h, expected <= %02h", tag, v, e.lim);
      end
    end else begin
      chk({tag, "_value"}, 32'(v), 32'(e.val));
      chk({tag, "_fallback"}, 32'(f), 32'(e.fb));
    end
    if (e.lat >= 0) chk({tag, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
  endtask

  // Monitors: compare whenever a DUT raises valid for a new result.
  initial begin
    bit seen0, seen1;
    seen0 = 1'b0;
    seen1 = 1'b0;
    forever begin
      @(negedge clk);
      if (bus0.valid && !seen0) begin
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL dut0_unexpected: got valid value %02h, expected no result", bus0.value);
        end else compare("dut0", q0.pop_front(), bus0.value, bus0.fallback);
      end
      seen0 = bus0.valid;
      if (bus1.valid && !seen1) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL dut1_unexpected: got valid value %02h, expected no result", bus1.value);
        end else compare("dut1", q1.pop_front(), bus1.value, bus1.fallback);
      end
      seen1 = bus1.valid;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input exp_t e0, input bit also1, input exp_t e1, input int hold,
                        input bit do_seed, input logic [7:0] sv);
    int n;
    @(negedge clk);
    bus0.req = 1'b1;
    bus0.limit = e0.lim;
    if (also1) begin
      bus1.req = 1'b1;
      bus1.limit = e1.lim;
    end
    @(negedge clk);
    bus0.req = 1'b0;
    bus1.req = 1'b0;
    e0.acc = cyc;
    e1.acc = cyc;
    q0.push_back(e0);
    if (also1) q1.push_back(e1);
    n = 0;
    if (do_seed) begin
      seed_load = 1'b1;
      seed_in = sv;
      @(negedge clk);
      seed_load = 1'b0;
      n = 1;
    end
    while (!bus0.valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.valid) begin
      tests++; fails++;
      $display("FAIL req_timeout: got no valid in 64 cycles, expected valid for limit %02h", e0.lim);
      return;
    end
    for (int k = 0; k < hold; k++) begin
      bus0.req = 1'b1;
      @(negedge clk);
      chk("hold_valid", 32'(bus0.valid), 32'd1);
      chk("hold_value", 32'(bus0.value), 32'(e0.val));
      chk("hold_req_ready", 32'(bus0.req_ready), 32'd0);
    end
    bus0.req = 1'b0;
    bus0.ready = 1'b1;
    @(negedge clk);
    bus0.ready = 1'b0;
    chk("valid_drop", 32'(bus0.valid), 32'd0);
    chk("req_ready_back", 32'(bus0.req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected the bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t none;
    logic [7:0] lims[4];
    logic [7:0] lim;
    none = mk(8'h00, 8'h00, 1'b0, 1'b1, -1);
    bus0.req = 1'b0; bus0.limit = 8'h00; bus0.ready = 1'b0;
    bus1.req = 1'b0; bus1.limit = 8'h00; bus1.ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state and first-try accept with full-range limit.
    do_reset();
    chk("rst_state", 32'(state0), 32'hA5);
    chk("rst_valid", 32'(bus0.valid), 32'd0);
    chk("rst_value", 32'(bus0.value), 32'd0);
    chk("rst_fallback", 32'(bus0.fallback), 32'd0);
    chk("rst_req_ready", 32'(bus0.req_ready), 32'd1);
    do_req(mk(8'hFF, 8'hA5, 1'b0, 1'b0, 1), 1'b0, none, 0, 1'b0, 8'h00);

    // One rejection on dut0; immediate fallback on dut1 (0x25 - 0x21).
    do_reset();
    do_req(mk(8'h20, 8'h0A, 1'b0, 1'b0, 2), 1'b1, mk(8'h20, 8'h04, 1'b1, 1'b0, 1), 0, 1'b0, 8'h00);

    // limit 0 always yields 0.
    do_reset();
    do_req(mk(8'h00, 8'h00, 1'b0, 1'b0, 1), 1'b0, none, 0, 1'b0, 8'h00);

    // Free-run sequence, zero-seed guard, external seed.
    do_reset();
    en = 1'b1;
    @(negedge clk); chk("run_1", 32'(state0), 32'h4A);
    @(negedge clk); chk("run_2", 32'(state0), 32'h95);
    @(negedge clk); chk("run_3", 32'(state0), 32'h2A);
    @(negedge clk); chk("run_4", 32'(state0), 32'h54);
    en = 1'b0;
    seed_load = 1'b1;
    seed_in = 8'h00;
    @(negedge clk); chk("seed_zero", 32'(state0), 32'hA5);
    seed_in = 8'h3C;
    @(negedge clk); chk("seed_3c", 32'(state0), 32'h3C);
    seed_load = 1'b0;

    // Back-pressure: result held with ready low, req ignored.
    do_reset();
    do_req(mk(8'hFF, 8'hA5, 1'b0, 1'b0, 1), 1'b0, none, 5, 1'b0, 8'h00);

    // Seed load in the first SEARCH cycle: 25,3C,39,33,27 rejected, 0E accepted.
    do_reset();
    do_req(mk(8'h20, 8'h0E, 1'b0, 1'b0, 6), 1'b0, none, 0, 1'b1, 8'h3C);

    // Reset in the middle of a search discards the result.
    do_reset();
    @(negedge clk);
    bus0.req = 1'b1;
    bus0.limit = 8'h20;
    @(negedge clk);
    bus0.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(bus0.valid), 32'd0);
    chk("abort_state", 32'(state0), 32'hA5);
    chk("abort_req_ready", 32'(bus0.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_result", 32'(bus0.valid), 32'd0);

    // Regression with free-running LFSR: every result must stay within limit.
    do_reset();
    en = 1'b1;
    lims[0] = 8'h00; lims[1] = 8'hFF; lims[2] = 8'h09; lims[3] = 8'h01;
    for (int i = 0; i < 150; i++) begin
      lim = (i < 4) ? lims[i] : 8'($urandom_range(0, 255));
      do_req(mk(lim, 8'h00, 1'b0, 1'b1, -1), 1'b1, mk(lim, 8'h00, 1'b0, 1'b1, -1), 0, 1'b0, 8'h00);
    end
    en = 1'b0;

    repeat (4) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
